rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Inverse of the core's instruction decoder: converts the core's 4-bit ALU Function code plus register and immediate fields back into RV32 machine words.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory through a stallable write port.
- Used as the boot-time / test program loader ahead of the single-cycle core.

Parameters:
- ADDR_W, 32, instruction-memory byte-address width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load session; honoured only in IDLE or DONE.
- start_addr  in  ADDR_W  first write address, latched on start.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder accepts fields this cycle.
- in_func  in  4  Function code 0..15.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  signed immediate / byte offset.
- imem_we  out  1  write request.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  write byte address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  state is LOAD or DRAIN.
- done  out  1  RET written and FIFO drained.
- err_pulse  out  1  one-cycle pulse, an instruction was dropped.
- err_cnt  out  ERR_W  saturating count of dropped instructions.
- word_count  out  ADDR_W  words written in this session.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO empty, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err_pulse=0, err_cnt=0, word_count=0. Reset mid-session discards FIFO contents and any pending write.
- States:
  - IDLE: on start, go to LOAD; latch start_addr; clear word_count and done.
  - LOAD: accept instructions.
  - DRAIN: entered on the cycle a valid RET is accepted; in_ready=0.
  - DONE: entered when the FIFO is empty in DRAIN; done=1 until the next start.
- start outside IDLE/DONE is ignored.
- in_ready = (state==LOAD) && !full. No same-cycle pop bypass.
- Accept = in_valid && in_ready.
  - Valid instruction: encode combinationally and push into the FIFO on the same edge.
  - Invalid instruction: not pushed; err_pulse=1 on the following cycle; err_cnt += 1, saturating at all-ones.
- Encoding (opcode/func3/func7):
  - R-type, opcode 0110011: 0 add 000/0000000; 1 sub 000/0100000; 3 mul 000/0000001; 4 div 100/0000001; 5 rem 110/0000001; 6 sll 001/0; 7 srl 101/0; 8 and 111/0; 9 or 110/0; 10 xor 100/0.
  - 2 addi: opcode 0010011, func3 000, I-format.
  - 11 lw: opcode 0000011, func3 010, I-format.
  - 12 sw: opcode 0100011, func3 010, S-format.
  - 13 beq / 14 bne: opcode 1100011, func3 000/001, B-format.
  - 15 RET: fixed word 0x00000073.
  - Fields ignored by a format are encoded as zero.
- Validity rules:
  - I and S formats: in_imm must lie in -2048..2047.
  - B format: in_imm must lie in -4096..4094 and be even.
  - Other codes: always valid.
- Write port:
  - imem_we = !empty in LOAD or DRAIN.
  - imem_wdata = FIFO head; imem_addr = current address.
  - On imem_we && imem_ready: pop, address += 4 (wraps modulo 2^ADDR_W), word_count += 1.
  - imem_we, addr and wdata stay stable while imem_ready=0.
- Latency: a word accepted at edge k is presented on imem_* after edge k and written at edge k+1 at the earliest.
- Full FIFO: in_ready=0; no loss.
- Simultaneous push and pop on a full FIFO cannot occur (in_ready=0 when full). Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.
- A RET that is dropped cannot happen, since RET is always valid.
- done asserts the cycle after the last pop following RET.

Decomposition:
- Shared package rv_pkg:
  - Function code constants FN_ADD..FN_RET.
  - Opcode constants OP_R, OP_I, OP_LW, OP_S, OP_B, OP_SYS.
  - func3/func7 constants.
  - Encoder state enum.
- The package is shared with the decoder so both agree.
- One natural sub-module, sync_fifo (width 32, depth DEPTH, full/empty), reusable elsewhere.
- Encoding logic is a pure function/always block inside the top.

Test Plan:
- start, start_addr=0x100; add rd=3 rs1=1 rs2=2 -> write 0x002081B3 @0x100; mul same regs -> 0x022081B3 @0x104.
- addi rd=5 rs1=0 imm=-1 -> 0xFFF00293; lw rd=6 rs1=2 imm=8 -> 0x00812303; sw rs2=7 rs1=2 imm=12 -> 0x00712623.
- beq rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; bne imm=3 (odd) -> no write, err_pulse=1, err_cnt=1; addi imm=2048 -> err_cnt=2.
- imem_ready=0 for 10 cycles while streaming -> in_ready drops after DEPTH pushes, imem_* held stable, no words lost, addresses contiguous after release.
- RET accepted with 2 words queued -> in_ready=0 immediately; 0x00000073 is the last write; done=1 once the FIFO is empty; word_count matches; new start restarts at the new start_addr.
- Assert rst_n=0 with 3 words queued -> all outputs zero immediately; after release no stale writes occur; start_addr=0xFFFFFFFC with two words -> second write wraps to address 0x0.

Source files
------------

// File: rtl/rv_instr_encoder_pkg.sv
// +----------------------------------------------------------------------------+
// | rv_pkg : function codes, opcodes and encoder states shared with decoder    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package rv_pkg;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_ADDI = 4'd2;
    localparam logic [3:0] FN_MUL  = 4'd3;
    localparam logic [3:0] FN_DIV  = 4'd4;
    localparam logic [3:0] FN_REM  = 4'd5;
    localparam logic [3:0] FN_SLL  = 4'd6;
    localparam logic [3:0] FN_SRL  = 4'd7;
    localparam logic [3:0] FN_AND  = 4'd8;
    localparam logic [3:0] FN_OR   = 4'd9;
    localparam logic [3:0] FN_XOR  = 4'd10;
    localparam logic [3:0] FN_LW   = 4'd11;
    localparam logic [3:0] FN_SW   = 4'd12;
    localparam logic [3:0] FN_BEQ  = 4'd13;
    localparam logic [3:0] FN_BNE  = 4'd14;
    localparam logic [3:0] FN_RET  = 4'd15;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_DIV = 3'b100;
    localparam logic [2:0] F3_REM = 3'b110;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [31:0] RET_WORD = 32'h0000_0073;

    typedef logic [1:0] enc_state_t;
    localparam enc_state_t ST_IDLE  = 2'd0;
    localparam enc_state_t ST_LOAD  = 2'd1;
    localparam enc_state_t ST_DRAIN = 2'd2;
    localparam enc_state_t ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/rv_instr_encoder_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with full/empty flags                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                r_mem[r_wr_ptr[AW-1:0]] <= wdata;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv_instr_encoder.sv
// +----------------------------------------------------------------------------+
// | rv_instr_encoder : Function code + fields -> RV32 words, streamed to imem  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_func,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] word_count
);

    enc_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_word_count;
    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_err_pulse;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_i_ok;
    logic        w_b_ok;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [31:0] w_head;
    logic        w_active;

    assign w_i_ok = (in_imm[31:11] == {21{in_imm[11]}});
    assign w_b_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (in_func)
            FN_ADD:  w_word = {F7_BASE, in_rs2, in_rs1, F3_ADD, in_rd, OP_R};
            FN_SUB:  w_word = {F7_SUB,  in_rs2, in_rs1, F3_ADD, in_rd, OP_R};
            FN_MUL:  w_word = {F7_MUL,  in_rs2, in_rs1, F3_ADD, in_rd, OP_R};
            FN_DIV:  w_word = {F7_MUL,  in_rs2, in_rs1, F3_DIV, in_rd, OP_R};
            FN_REM:  w_word = {F7_MUL,  in_rs2, in_rs1, F3_REM, in_rd, OP_R};
            FN_SLL:  w_word = {F7_BASE, in_rs2, in_rs1, F3_SLL, in_rd, OP_R};
            FN_SRL:  w_word = {F7_BASE, in_rs2, in_rs1, F3_SRL, in_rd, OP_R};
            FN_AND:  w_word = {F7_BASE, in_rs2, in_rs1, F3_AND, in_rd, OP_R};
            FN_OR:   w_word = {F7_BASE, in_rs2, in_rs1, F3_OR,  in_rd, OP_R};
            FN_XOR:  w_word = {F7_BASE, in_rs2, in_rs1, F3_XOR, in_rd, OP_R};
            FN_ADDI: begin
                w_word  = {in_imm[11:0], in_rs1, F3_ADD, in_rd, OP_I};
                w_legal = w_i_ok;
            end
            FN_LW: begin
                w_word  = {in_imm[11:0], in_rs1, F3_LW, in_rd, OP_LW};
                w_legal = w_i_ok;
            end
            FN_SW: begin
                w_word  = {in_imm[11:5], in_rs2, in_rs1, F3_LW, in_imm[4:0], OP_S};
                w_legal = w_i_ok;
            end
            FN_BEQ, FN_BNE: begin
                w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                           (in_func == FN_BNE) ? F3_BNE : F3_BEQ,
                           in_imm[4:1], in_imm[11], OP_B};
                w_legal = w_b_ok;
            end
            FN_RET:  w_word = RET_WORD;
            default: w_word = '0;
        endcase
    end

    assign w_active = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign in_ready = (r_state == ST_LOAD) && !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign imem_we  = w_active && !w_empty;
    assign w_pop    = imem_we && imem_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_word),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Storage is not cleared by reset, so mask the head when nothing is pending.
    assign imem_wdata = imem_we ? w_head : 32'h0;
    assign imem_addr  = r_addr;
    assign busy       = w_active;
    assign done       = (r_state == ST_DONE);
    assign err_pulse  = r_err_pulse;
    assign err_cnt    = r_err_cnt;
    assign word_count = r_word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_word_count <= '0;
            r_err_cnt    <= '0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_err_pulse <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end

            if (w_pop) begin
                r_addr       <= r_addr + ADDR_W'(4);
                r_word_count <= r_word_count + ADDR_W'(1);
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_LOAD;
                        r_addr       <= start_addr;
                        r_word_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept && (in_func == FN_RET)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
// +----------------------------------------------------------------------------+
// | tb_rv_instr_encoder : directed self-checking bench for rv_instr_encoder    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_rv_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] start_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_func;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        imem_we;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic [31:0] word_count;

    int checks;
    int passed;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    rv_instr_encoder #(
        .ADDR_W (32),
        .DEPTH  (4),
        .ERR_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func    (in_func),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change 1ns after a rising edge, so a write seen here lands on the next edge.
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    task automatic send(input logic [3:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        bit got;
        got      = 1'b0;
        in_func  = f;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) $display("FAIL send_timeout: in_ready=0 required 1 (func %0d)", f);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] a);
        start      = 1'b1;
        start_addr = a;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wa_q.size() >= n) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) $display("FAIL write_timeout: writes=%0d required %0d", wa_q.size(), n);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, imem_we, busy, done, err_pulse} !== 5'b0)
            $display("FAIL reset_flags: got %b required 00000", {in_ready, imem_we, busy, done, err_pulse});
        else passed++;
        checks++;
        if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h required 0", imem_addr);
        else passed++;
        checks++;
        if (imem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h required 0", imem_wdata);
        else passed++;
        checks++;
        if (err_cnt !== 8'h0) $display("FAIL reset_errcnt: got %0d required 0", err_cnt);
        else passed++;
        checks++;
        if (word_count !== 32'h0) $display("FAIL reset_wordcount: got %0d required 0", word_count);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encode();
        logic [31:0] exp_d[6];
        int base;
        exp_d[0] = 32'h002081B3;
        exp_d[1] = 32'h022081B3;
        exp_d[2] = 32'hFFF00293;
        exp_d[3] = 32'h00812303;
        exp_d[4] = 32'h00712623;
        exp_d[5] = 32'hFE208CE3;
        base = wa_q.size();
        imem_ready = 1'b1;
        do_start(32'h100);
        @(negedge clk);
        checks++;
        if (!busy || word_count !== 32'h0 || imem_addr !== 32'h100)
            $display("FAIL start_state: busy=%b wc=%0d addr=%h required 1 0 100", busy, word_count, imem_addr);
        else passed++;
        @(posedge clk); #1;
        send(4'd0,  5'd3, 5'd1, 5'd2, 32'd0);
        send(4'd3,  5'd3, 5'd1, 5'd2, 32'd0);
        send(4'd2,  5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        send(4'd11, 5'd6, 5'd2, 5'd0, 32'd8);
        send(4'd12, 5'd0, 5'd2, 5'd7, 32'd12);
        send(4'd13, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        wait_writes(base + 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < wd_q.size()) begin
                checks++;
                if (wd_q[base+i] !== exp_d[i] || wa_q[base+i] !== 32'h100 + 32'(4*i))
                    $display("FAIL encode_%0d: got %h@%h required %h@%h", i, wd_q[base+i],
                             wa_q[base+i], exp_d[i], 32'h100 + 32'(4*i));
                else passed++;
            end
        end
    endtask

    task automatic test_errors();
        int base;
        @(posedge clk); #1;
        do_start(32'h500);
        base = wa_q.size();
        send(4'd14, 5'd0, 5'd1, 5'd2, 32'd3);
        @(negedge clk);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1)
            $display("FAIL odd_branch: pulse=%b cnt=%0d required 1 1", err_pulse, err_cnt);
        else passed++;
        @(negedge clk);
        checks++;
        if (err_pulse !== 1'b0) $display("FAIL pulse_width: pulse=%b required 0", err_pulse);
        else passed++;
        @(posedge clk); #1;
        send(4'd2, 5'd5, 5'd0, 5'd0, 32'd2048);
        @(negedge clk);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd2)
            $display("FAIL addi_range: pulse=%b cnt=%0d required 1 2", err_pulse, err_cnt);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() !== base || imem_we !== 1'b0)
            $display("FAIL dropped_write: writes=%0d we=%b required %0d 0", wa_q.size(), imem_we, base);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d[5];
        int base;
        bit held;
        exp_d[0] = 32'h00208533;
        exp_d[1] = 32'h002085B3;
        exp_d[2] = 32'h00208633;
        exp_d[3] = 32'h002086B3;
        exp_d[4] = 32'h00208733;
        base = wa_q.size();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd0, 5'(10 + i), 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL full_ready: in_ready=%b required 0", in_ready);
        else passed++;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (imem_we !== 1'b1 || imem_addr !== 32'h118 || imem_wdata !== exp_d[0] || in_ready !== 1'b0)
                held = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!held) $display("FAIL stall_hold: we=%b addr=%h data=%h required 1 118 %h",
                            imem_we, imem_addr, imem_wdata, exp_d[0]);
        else passed++;
        @(posedge clk); #1;
        imem_ready = 1'b1;
        send(4'd0, 5'd14, 5'd1, 5'd2, 32'd0);
        wait_writes(base + 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < wd_q.size()) begin
                checks++;
                if (wd_q[base+i] !== exp_d[i] || wa_q[base+i] !== 32'h118 + 32'(4*i))
                    $display("FAIL stream_%0d: got %h@%h required %h@%h", i, wd_q[base+i],
                             wa_q[base+i], exp_d[i], 32'h118 + 32'(4*i));
                else passed++;
            end
        end
    endtask

    task automatic test_ret();
        bit got;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        send(4'd1,  5'd3, 5'd1, 5'd2, 32'd0);
        send(4'd10, 5'd4, 5'd5, 5'd6, 32'd0);
        send(4'd15, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL drain_state: ready=%b busy=%b done=%b required 0 1 0", in_ready, busy, done);
        else passed++;
        @(posedge clk); #1;
        imem_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || busy !== 1'b0) $display("FAIL done_flag: done=%b busy=%b required 1 0", done, busy);
        else passed++;
        checks++;
        if (wd_q.size() < 3 || wd_q[$] !== 32'h73 || wa_q[$] !== 32'h134 ||
            wd_q[wd_q.size()-3] !== 32'h402081B3 || wd_q[wd_q.size()-2] !== 32'h0062C233)
            $display("FAIL ret_tail: last=%h@%h required 00000073@00000134", wd_q[$], wa_q[$]);
        else passed++;
        checks++;
        if (word_count !== 32'd14) $display("FAIL word_count: got %0d required 14", word_count);
        else passed++;
        @(posedge clk); #1;
        do_start(32'h200);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || imem_addr !== 32'h200 || word_count !== 32'h0)
            $display("FAIL restart: done=%b addr=%h wc=%0d required 0 200 0", done, imem_addr, word_count);
        else passed++;
        @(posedge clk); #1;
        send(4'd9, 5'd7, 5'd8, 5'd9, 32'd0);
        wait_writes(wa_q.size() + 1);
        checks++;
        if (wd_q[$] !== 32'h009463B3 || wa_q[$] !== 32'h200)
            $display("FAIL restart_write: got %h@%h required 009463B3@00000200", wd_q[$], wa_q[$]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int base;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_we, busy, in_ready} !== 3'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0 || err_cnt !== 8'h0)
            $display("FAIL mid_reset: we=%b busy=%b addr=%h data=%h cnt=%0d required all zero",
                     imem_we, busy, imem_addr, imem_wdata, err_cnt);
        else passed++;
        #2;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        base = wa_q.size();
        repeat (6) @(negedge clk);
        checks++;
        if (wa_q.size() !== base || imem_we !== 1'b0)
            $display("FAIL stale_write: writes=%0d we=%b required %0d 0", wa_q.size(), imem_we, base);
        else passed++;
        @(posedge clk); #1;
        do_start(32'hFFFF_FFFC);
        send(4'd11, 5'd6, 5'd2, 5'd0, 32'd8);
        send(4'd12, 5'd0, 5'd2, 5'd7, 32'd12);
        wait_writes(base + 2);
        if (wa_q.size() >= base + 2) begin
            checks++;
            if (wa_q[base] !== 32'hFFFF_FFFC || wd_q[base] !== 32'h00812303)
                $display("FAIL wrap_first: got %h@%h required 00812303@FFFFFFFC", wd_q[base], wa_q[base]);
            else passed++;
            checks++;
            if (wa_q[base+1] !== 32'h0 || wd_q[base+1] !== 32'h00712623)
                $display("FAIL wrap_second: got %h@%h required 00712623@00000000", wd_q[base+1], wa_q[base+1]);
            else passed++;
        end
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        in_valid   = 1'b0;
        in_func    = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_imm     = '0;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_encode();
        test_errors();
        test_backpressure();
        test_ret();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
